// File: rtl/joy_db15_frame_reader.sv
// Serial frame reader for the DB15 UserIO joystick adapter: drives the shift clock and
// load strobe, deserialises 24 bits and publishes both joystick words atomically.
module joy_db15_frame_reader #(
  parameter int CLK_DIV   = 64,
  parameter int GAP_TICKS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        present,
  output logic        frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [4:0]       BIT_LAST = 5'd23;

  typedef enum logic [1:0] {ST_GAP, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [4:0]       bit_idx;
  logic             phase;
  logic [23:0]      raw;
  logic [1:0]       data_sync;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_sync <= 2'b11;
    else       data_sync <= {data_sync[0], JOY_DATA};
  end

  // The divider pauses for the single DONE clk, so each frame costs exactly one extra clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  div_cnt <= '0;
    else if (state != ST_DONE)  div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_GAP;
      gap_cnt    <= '0;
      bit_idx    <= '0;
      phase      <= 1'b0;
      raw        <= '0;
      JOY_CLK    <= 1'b1;
      JOY_LOAD   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      present    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        // Abandon any frame in flight and park the bus idle-high.
        state     <= ST_GAP;
        gap_cnt   <= '0;
        bit_idx   <= '0;
        phase     <= 1'b0;
        raw       <= '0;
        JOY_CLK   <= 1'b1;
        JOY_LOAD  <= 1'b1;
        joystick1 <= '0;
        joystick2 <= '0;
        present   <= 1'b0;
      end else begin
        case (state)
          ST_GAP: if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt  <= '0;
              phase    <= 1'b0;
              JOY_LOAD <= 1'b0;
              state    <= ST_LOAD;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          ST_LOAD: if (tick) begin
            if (phase) begin
              phase    <= 1'b0;
              bit_idx  <= '0;
              JOY_LOAD <= 1'b1;
              state    <= ST_SHIFT;
            end else begin
              phase <= 1'b1;
            end
          end
          ST_SHIFT: if (tick) begin
            if (!phase) begin
              raw[bit_idx] <= data_sync[1];
              JOY_CLK      <= 1'b0;
              phase        <= 1'b1;
            end else begin
              // Rising edge here makes the adapter present the next bit.
              JOY_CLK <= 1'b1;
              phase   <= 1'b0;
              if (bit_idx == BIT_LAST) state   <= ST_DONE;
              else                     bit_idx <= bit_idx + 1'b1;
            end
          end
          ST_DONE: begin
            // An all-zero wire means a shorted data line, reported as absent.
            if (raw == '0) begin
              joystick1 <= '0;
              joystick2 <= '0;
              present   <= 1'b0;
            end else begin
              joystick1 <= {4'b0000, ~raw[11:0]};
              joystick2 <= {4'b0000, ~raw[23:12]};
              present   <= 1'b1;
            end
            frame_done <= 1'b1;
            gap_cnt    <= '0;
            state      <= ST_GAP;
          end
          default: state <= ST_GAP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_frame_reader.sv
// Self-checking bench: models the two-register adapter and checks frames, pin timing,
// enable/reset behaviour and random contents against a button-level reference.
module tb_joy_db15_frame_reader;

  localparam int CLK_DIV   = 4;
  localparam int GAP_TICKS = 2;
  localparam int PERIOD    = (2 + 48 + GAP_TICKS) * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        present;
  logic        frame_done;

  joy_db15_frame_reader #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .JOY_DATA   (JOY_DATA),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .present    (present),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Adapter: parallel contents captured on load, shifted out LSB first on JOY_CLK rise.
  logic [11:0] p1, p2;
  logic        tie0;
  logic [23:0] sr = '1;

  always @(posedge JOY_CLK or negedge JOY_LOAD) begin
    if (!JOY_LOAD) sr <= {p2, p1};
    else           sr <= {1'b1, sr[23:1]};
  end

  assign JOY_DATA = tie0 ? 1'b0 : sr[0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (frame_done !== 1'b1 && cycles < 3 * PERIOD);
    if (frame_done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no frame_done within %0d clk", 3 * PERIOD);
    end
  endtask

  task automatic wait_load(input logic val);
    int n = 0;
    while (JOY_LOAD !== val && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (JOY_LOAD !== val) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_load: JOY_LOAD never reached %b", val);
    end
  endtask

  // Reference: each wire bit low means that button is pressed; an all-low wire is "absent".
  function automatic void model(input logic [11:0] c1, input logic [11:0] c2, input logic t0,
                                output logic [15:0] j1, output logic [15:0] j2, output logic pres);
    logic [11:0] w1, w2;
    w1 = t0 ? 12'h000 : c1;
    w2 = t0 ? 12'h000 : c2;
    pres = (w1 != 12'h000) || (w2 != 12'h000);
    j1 = 16'h0000;
    j2 = 16'h0000;
    if (pres) begin
      for (int b = 0; b < 12; b++) begin
        if (w1[b] == 1'b0) j1 = j1 + (16'h0001 << b);
        if (w2[b] == 1'b0) j2 = j2 + (16'h0001 << b);
      end
    end
  endfunction

  typedef struct {
    logic [11:0] p1;
    logic [11:0] p2;
    logic        tie0;
    logic [15:0] j1;
    logic [15:0] j2;
    logic        pres;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2;
    int load_low, rises, bad_order, bad_low, low_run, stray;
    logic prev_clk;
    logic [15:0] e1, e2;
    logic ep;

    vecs[0] = '{12'hFFE, 12'hBFF, 1'b0, 16'h0001, 16'h0400, 1'b1};
    vecs[1] = '{12'hFFE, 12'hBFF, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{12'hFFF, 12'hFFF, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[3] = '{12'h000, 12'h000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{12'h555, 12'hAAA, 1'b0, 16'h0AAA, 16'h0555, 1'b1};
    vecs[5] = '{12'hFFF, 12'h000, 1'b0, 16'h0000, 16'h0FFF, 1'b1};
    vecs[6] = '{12'h7FF, 12'hFFF, 1'b0, 16'h0800, 16'h0000, 1'b1};

    reset  = 1'b1;
    enable = 1'b1;
    p1     = 12'hFFE;
    p2     = 12'hBFF;
    tie0   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_joy_clk",    JOY_CLK,    1);
    check("reset_joy_load",   JOY_LOAD,   1);
    check("reset_joystick1",  joystick1,  0);
    check("reset_joystick2",  joystick2,  0);
    check("reset_present",    present,    0);
    check("reset_frame_done", frame_done, 0);
    reset = 1'b0;

    // Table-driven frames; contents are changed in the gap right after each publish.
    for (int i = 0; i < 7; i++) begin
      p1   = vecs[i].p1;
      p2   = vecs[i].p2;
      tie0 = vecs[i].tie0;
      wait_done(c);
      check($sformatf("vec%0d_joystick1", i), joystick1, vecs[i].j1);
      check($sformatf("vec%0d_joystick2", i), joystick2, vecs[i].j2);
      check($sformatf("vec%0d_present", i),   present,   vecs[i].pres);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), frame_done, 0);
    end

    // Frame period.
    p1 = 12'hFFE;
    p2 = 12'hBFF;
    wait_done(c);
    wait_done(c);
    check("frame_period", c, PERIOD);
    check("period_joystick1", joystick1, 16'h0001);

    // Pin timing over one full frame.
    load_low = 0; rises = 0; bad_order = 0; bad_low = 0; low_run = 0;
    prev_clk = JOY_CLK;
    for (int i = 0; i < PERIOD - 1; i++) begin
      @(negedge clk);
      if (!JOY_LOAD) load_low++;
      if (JOY_CLK && !prev_clk) begin
        rises++;
        if (load_low != 8 || !JOY_LOAD) bad_order++;
        if (low_run != 4) bad_low++;
      end
      if (!JOY_CLK) low_run++;
      else          low_run = 0;
      prev_clk = JOY_CLK;
    end
    check("load_low_clks",    load_low,  8);
    check("joy_clk_rises",    rises,     24);
    check("rise_after_load",  bad_order, 0);
    check("joy_clk_low_clks", bad_low,   0);
    wait_done(c);

    // Contents change mid-shift: the frame in flight keeps the loaded values.
    wait_load(1'b0);
    wait_load(1'b1);
    repeat (40) @(negedge clk);
    p1 = 12'h7FF;
    wait_done(c);
    check("midshift_old_joystick1", joystick1, 16'h0001);
    wait_done(c);
    check("midshift_new_joystick1", joystick1, 16'h0800);
    check("midshift_new_joystick2", joystick2, 16'h0400);

    // Disable during bit 10, then re-enable.
    wait_load(1'b0);
    wait_load(1'b1);
    repeat (84) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_joy_clk",   JOY_CLK,   1);
    check("disable_joy_load",  JOY_LOAD,  1);
    check("disable_joystick1", joystick1, 0);
    check("disable_joystick2", joystick2, 0);
    check("disable_present",   present,   0);
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_done || !JOY_LOAD || !JOY_CLK) stray++;
    end
    check("disabled_bus_idle", stray, 0);
    enable = 1'b1;
    wait_done(c);
    n_checks++;
    if (c < 206 || c > 209) begin
      n_fail++;
      $display("FAIL reenable_latency: got %0d clk, expected 206..209", c);
    end
    check("reenable_joystick1", joystick1, 16'h0800);
    check("reenable_joystick2", joystick2, 16'h0400);

    // Asynchronous reset between clock edges.
    wait_load(1'b0);
    wait_load(1'b1);
    c2 = 0;
    while (JOY_CLK !== 1'b0 && c2 < 16) begin
      @(negedge clk);
      c2++;
    end
    check("pre_reset_joy_clk_low", JOY_CLK, 0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_joy_clk",    JOY_CLK,   1);
    check("async_reset_joy_load",   JOY_LOAD,  1);
    check("async_reset_joystick1",  joystick1, 0);
    check("async_reset_joystick2",  joystick2, 0);
    check("async_reset_present",    present,   0);
    @(negedge clk);
    reset = 1'b0;
    wait_done(c);
    check("post_reset_joystick1", joystick1, 16'h0800);
    check("post_reset_present",   present,   1);

    // Random adapter contents against the reference model.
    for (int i = 0; i < 16; i++) begin
      p1   = 12'($urandom_range(0, 4095));
      p2   = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) p1 = 12'hFFF;
      if ($urandom_range(0, 7) == 0) p2 = 12'h000;
      tie0 = ($urandom_range(0, 9) == 0);
      model(p1, p2, tie0, e1, e2, ep);
      wait_done(c);
      check($sformatf("rand%0d_joystick1", i), joystick1, e1);
      check($sformatf("rand%0d_joystick2", i), joystick2, e2);
      check($sformatf("rand%0d_present", i),   present,   ep);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
